segment_scan_decoder: RTL and testbench
=======================================

// Module: segment_scan_decoder
// PURPOSE
//  Receive side of the multiplexed 7-segment display bus: snoops seg/digit-select lines,
//  decodes each settled digit's segment pattern back to a 4-bit BCD value, and publishes a
//  debounced per-digit value once it is stable over STABLE_CNT scan visits. Used for
//  display loopback checking and for reading the clock's time off the pins.
// PARAMETERS
//  NUM_DIGITS  4  number of multiplexed digits (width of dig_sel)
//  STABLE_CNT  3  consecutive identical captures of a digit required before publishing (>=1, <=15)
// PORTS
//  clk           in   1             system clock, all logic on rising edge
//  rst_n         in   1             synchronous reset, active-low
//  seg_in        in   7             segment lines {g,f,e,d,c,b,a}, active-high
//  dig_sel       in   NUM_DIGITS    digit enables, active-high, expected one-hot or zero
//  digits_out    out  4*NUM_DIGITS  published values; digit i at [4i+3:4i]
//  valid_out     out  NUM_DIGITS    bit i set once digit i has been published since reset
//  update_pulse  out  1             1-cycle pulse when any digit's published value is written
//  pattern_err   out  1             1-cycle pulse on a capture with an undecodable pattern
//  onehot_err    out  1             high each cycle the staged dig_sel has >1 bit set
// BEHAVIOUR
//  Reset (rst_n=0 at a clk edge): digits_out all 4'hF, valid_out 0, update_pulse 0,
//   pattern_err 0, onehot_err 0, s1/s2 stages 0, per-digit cand=4'hF, cnt=0.
//  Pipeline: s1 <= {seg_in,dig_sel}; s2 <= s1. No combinational input->output path.
//  Capture event: s2.dig_sel one-hot AND s1.dig_sel != s2.dig_sel (last cycle of a scan
//   interval => settled segments). Captured pattern = s2.seg, digit index = set bit of s2.
//  Latency: pins in last interval cycle sampled at edge E0 -> outputs updated after E0+2.
//  Decode: 3f->0 06->1 5b->2 4f->3 66->4 6d->5 7d->6 07->7 7f->8 6f->9; 00->4'hF (blank);
//   any other pattern -> 4'hE and pattern_err pulses on the same edge as the capture.
//  Per-digit debounce on capture of digit i with decoded value v:
//   v==cand[i]: cnt[i] <= sat(cnt[i]+1, STABLE_CNT); else cand[i]<=v, cnt[i]<=1.
//   Publish when new cnt[i]==STABLE_CNT AND (cand value != digits_out[i] OR valid_out[i]==0):
//   digits_out[i]<=v, valid_out[i]<=1, update_pulse<=1. Otherwise update_pulse<=0.
//   STABLE_CNT=1: every capture whose value differs is published immediately.
//  Once saturated, identical captures cause no write and no pulse.
//  Blank (F) and error (E) values publish exactly like digits.
//  dig_sel==0 in s2: idle, no capture. s2.dig_sel with >=2 bits: onehot_err=1 that cycle,
//   no capture; a following one-hot interval is captured normally at its end.
//  Only one digit can be captured per cycle; uncaptured digits hold cand/cnt/outputs.
//  Interval of a single cycle is still captured (s1 differs from s2).
//  Mid-operation reset discards s1/s2 and all debounce state; the interval in flight at
//   reset release is captured only if its end is seen after two clean stage loads.
// TESTING
//  1 Reset: hold rst_n=0 2 cycles -> digits_out=16'hFFFF, valid_out=0, all pulses 0.
//  2 Scan digits 0..3 with 06,5b,4f,66, 8 cycles each, 3 rounds -> after 3rd round
//    digits_out=16'h4321, valid_out=4'hF, 4 update_pulses total, each 2 edges after interval end.
//  3 Steady 16'h4321, then one visit of digit 2 shows 7f -> no change, no pulse; digit 2 needs
//    3 further 4f captures before any pulse (none, value unchanged).
//  4 Digit 0 shows 49 for 3 visits -> pattern_err pulse per capture; third -> digits_out[3:0]=E.
//  5 dig_sel=4'b0110 for 5 cycles -> onehot_err high 5 cycles, no capture, no pulses.
//  6 rst_n=0 one cycle in middle of round 2 of test 2 -> outputs back to reset values; 3 full
//    rounds after release needed to re-publish 16'h4321.

Source files
------------

// File: rtl/segment_scan_decoder.sv
// segment_scan_decoder
//   Snoops a multiplexed 7-segment display bus. It decodes the settled segment pattern of each
//   scanned digit back to BCD. A value is published per digit once it has been captured
//   STABLE_CNT times in a row.
// Ports
//   clk           rising-edge system clock
//   rst_n         synchronous active-low reset
//   seg_in        segment lines {g,f,e,d,c,b,a}, active-high
//   dig_sel       digit enables, active-high, expected one-hot or zero
//   digits_out    published values, digit i at [4i+3:4i]
//   valid_out     bit i set once digit i has been published since reset
//   update_pulse  1-cycle pulse when a published value is written
//   pattern_err   1-cycle pulse on a capture of an undecodable pattern
//   onehot_err    high while the staged dig_sel has more than one bit set
module segment_scan_decoder #(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned STABLE_CNT = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [6:0]              seg_in,
  input  logic [NUM_DIGITS-1:0]   dig_sel,
  output logic [4*NUM_DIGITS-1:0] digits_out,
  output logic [NUM_DIGITS-1:0]   valid_out,
  output logic                    update_pulse,
  output logic                    pattern_err,
  output logic                    onehot_err
);

  localparam logic [3:0]            StableCnt = 4'(STABLE_CNT);
  localparam logic [NUM_DIGITS-1:0] SelOne    = NUM_DIGITS'(1);

  logic [6:0]            s1_seg, s2_seg;
  logic [NUM_DIGITS-1:0] s1_sel, s2_sel;
  logic [3:0]            cand_q [NUM_DIGITS];
  logic [3:0]            cnt_q  [NUM_DIGITS];

  logic                  sel_multi;
  logic                  capture;
  logic [3:0]            dec_val;
  logic                  dec_bad;
  logic [3:0]            cnt_new [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] publish;

  // Clearing the lowest set bit leaves something only when two or more bits are set.
  always_comb begin
    sel_multi = |(s2_sel & (s2_sel - SelOne));
    // A change of select between the stages marks the last cycle of a scan interval, where
    // the segments have had the whole interval to settle.
    capture   = (s2_sel != '0) && !sel_multi && (s1_sel != s2_sel);
  end

  always_comb begin
    dec_bad = 1'b0;
    case (s2_seg)
      7'h3f:   dec_val = 4'd0;
      7'h06:   dec_val = 4'd1;
      7'h5b:   dec_val = 4'd2;
      7'h4f:   dec_val = 4'd3;
      7'h66:   dec_val = 4'd4;
      7'h6d:   dec_val = 4'd5;
      7'h7d:   dec_val = 4'd6;
      7'h07:   dec_val = 4'd7;
      7'h7f:   dec_val = 4'd8;
      7'h6f:   dec_val = 4'd9;
      7'h00:   dec_val = 4'hF;
      default: begin
        dec_val = 4'hE;
        dec_bad = 1'b1;
      end
    endcase
  end

  // Debounce next-state for every digit; only the one selected in s2 is committed.
  always_comb begin
    publish = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (dec_val == cand_q[i]) begin
        cnt_new[i] = (cnt_q[i] == StableCnt) ? cnt_q[i] : cnt_q[i] + 4'd1;
      end else begin
        cnt_new[i] = 4'd1;
      end
      publish[i] = capture && s2_sel[i] && (cnt_new[i] == StableCnt) &&
                   ((dec_val != digits_out[4*i +: 4]) || !valid_out[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_seg       <= '0;
      s1_sel       <= '0;
      s2_seg       <= '0;
      s2_sel       <= '0;
      digits_out   <= '1;
      valid_out    <= '0;
      update_pulse <= 1'b0;
      pattern_err  <= 1'b0;
      onehot_err   <= 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        cand_q[i] <= 4'hF;
        cnt_q[i]  <= 4'd0;
      end
    end else begin
      s1_seg       <= seg_in;
      s1_sel       <= dig_sel;
      s2_seg       <= s1_seg;
      s2_sel       <= s1_sel;
      onehot_err   <= sel_multi;
      pattern_err  <= capture && dec_bad;
      update_pulse <= |publish;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (capture && s2_sel[i]) begin
          cand_q[i] <= dec_val;
          cnt_q[i]  <= cnt_new[i];
          if (publish[i]) begin
            digits_out[4*i +: 4] <= dec_val;
            valid_out[i]         <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_segment_scan_decoder.sv
// Directed bench for segment_scan_decoder (4 digits, STABLE_CNT = 3).
// Inputs change on falling edges; outputs are sampled on falling edges.
module tb_segment_scan_decoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [6:0]  seg_in;
  logic [3:0]  dig_sel;
  logic [15:0] digits_out;
  logic [3:0]  valid_out;
  logic        update_pulse;
  logic        pattern_err;
  logic        onehot_err;

  int checks = 0;
  int errors = 0;
  int pulse_cnt = 0;
  int perr_cnt = 0;
  int oherr_cnt = 0;
  int base_p, base_e, base_o;

  segment_scan_decoder #(
    .NUM_DIGITS(4),
    .STABLE_CNT(3)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .seg_in       (seg_in),
    .dig_sel      (dig_sel),
    .digits_out   (digits_out),
    .valid_out    (valid_out),
    .update_pulse (update_pulse),
    .pattern_err  (pattern_err),
    .onehot_err   (onehot_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (update_pulse === 1'b1) pulse_cnt++;
    if (pattern_err === 1'b1)  perr_cnt++;
    if (onehot_err === 1'b1)   oherr_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Hold sel/seg for n clock cycles.
  task automatic run(input logic [3:0] sel, input logic [6:0] seg, input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      dig_sel = sel;
      seg_in  = seg;
    end
  endtask

  task automatic scan(input logic [6:0] s0, input logic [6:0] s1, input logic [6:0] s2,
                      input logic [6:0] s3, input int n);
    run(4'b0001, s0, n);
    run(4'b0010, s1, n);
    run(4'b0100, s2, n);
    run(4'b1000, s3, n);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0;
    dig_sel = '0;
    seg_in = '0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n   = 1'b0;
    dig_sel = '0;
    seg_in  = '0;

    // 1: reset held for two cycles
    run(4'b0000, 7'h00, 2);
    rst_n = 1'b1;
    chk("rst_digits", 32'(digits_out), 32'hFFFF);
    chk("rst_valid", 32'(valid_out), 32'h0);
    chk("rst_upd", 32'(update_pulse), 32'h0);
    chk("rst_perr", 32'(pattern_err), 32'h0);
    chk("rst_oherr", 32'(onehot_err), 32'h0);

    // 2: three rounds of 1,2,3,4; publishes land in round 3
    run(4'b0000, 7'h00, 2);
    base_p = pulse_cnt;
    scan(7'h06, 7'h5b, 7'h4f, 7'h66, 8);
    scan(7'h06, 7'h5b, 7'h4f, 7'h66, 8);
    chk("r2_valid", 32'(valid_out), 32'h0);
    chk("r2_digits", 32'(digits_out), 32'hFFFF);
    run(4'b0001, 7'h06, 8);
    run(4'b0010, 7'h5b, 1);            // edge E0+1 follows
    run(4'b0010, 7'h5b, 1);
    chk("lat_e1_upd", 32'(update_pulse), 32'h0);
    chk("lat_e1_dig", 32'(digits_out), 32'hFFFF);
    run(4'b0010, 7'h5b, 1);
    chk("lat_e2_upd", 32'(update_pulse), 32'h1);
    chk("lat_e2_dig", 32'(digits_out), 32'hFFF1);
    chk("lat_e2_valid", 32'(valid_out), 32'h1);
    run(4'b0010, 7'h5b, 5);
    run(4'b0100, 7'h4f, 8);
    run(4'b1000, 7'h66, 8);
    run(4'b0000, 7'h00, 4);
    chk("t2_digits", 32'(digits_out), 32'h4321);
    chk("t2_valid", 32'(valid_out), 32'hF);
    chk("t2_pulses", 32'(pulse_cnt - base_p), 32'd4);

    // 3: a single glitch visit of digit 2 does not change anything
    base_p = pulse_cnt;
    scan(7'h06, 7'h5b, 7'h7f, 7'h66, 8);
    run(4'b0000, 7'h00, 4);
    chk("t3_glitch_dig", 32'(digits_out), 32'h4321);
    scan(7'h06, 7'h5b, 7'h4f, 7'h66, 8);
    scan(7'h06, 7'h5b, 7'h4f, 7'h66, 8);
    scan(7'h06, 7'h5b, 7'h4f, 7'h66, 8);
    run(4'b0000, 7'h00, 4);
    chk("t3_digits", 32'(digits_out), 32'h4321);
    chk("t3_pulses", 32'(pulse_cnt - base_p), 32'd0);

    // 4: undecodable pattern on digit 0 for three visits publishes E
    base_p = pulse_cnt;
    base_e = perr_cnt;
    scan(7'h49, 7'h5b, 7'h4f, 7'h66, 8);
    scan(7'h49, 7'h5b, 7'h4f, 7'h66, 8);
    run(4'b0000, 7'h00, 4);
    chk("t4_pre_dig", 32'(digits_out), 32'h4321);
    scan(7'h49, 7'h5b, 7'h4f, 7'h66, 8);
    run(4'b0000, 7'h00, 4);
    chk("t4_perr", 32'(perr_cnt - base_e), 32'd3);
    chk("t4_digits", 32'(digits_out), 32'h432E);
    chk("t4_pulses", 32'(pulse_cnt - base_p), 32'd1);

    // single-cycle intervals are still captured
    base_p = pulse_cnt;
    scan(7'h06, 7'h5b, 7'h4f, 7'h66, 1);
    scan(7'h06, 7'h5b, 7'h4f, 7'h66, 1);
    scan(7'h06, 7'h5b, 7'h4f, 7'h66, 1);
    run(4'b0000, 7'h00, 4);
    chk("t4_short_dig", 32'(digits_out), 32'h4321);
    chk("t4_short_pulses", 32'(pulse_cnt - base_p), 32'd1);

    // 5: two digits selected at once
    base_p = pulse_cnt;
    base_e = perr_cnt;
    base_o = oherr_cnt;
    run(4'b0110, 7'h7f, 5);
    run(4'b0000, 7'h00, 4);
    chk("t5_oherr", 32'(oherr_cnt - base_o), 32'd5);
    chk("t5_pulses", 32'(pulse_cnt - base_p), 32'd0);
    chk("t5_perr", 32'(perr_cnt - base_e), 32'd0);
    chk("t5_digits", 32'(digits_out), 32'h4321);

    // 6: reset in the middle of round 2
    pulse_reset();
    run(4'b0000, 7'h00, 2);
    scan(7'h06, 7'h5b, 7'h4f, 7'h66, 8);
    run(4'b0001, 7'h06, 8);
    run(4'b0010, 7'h5b, 8);
    pulse_reset();
    chk("t6_rst_digits", 32'(digits_out), 32'hFFFF);
    chk("t6_rst_valid", 32'(valid_out), 32'h0);
    chk("t6_rst_upd", 32'(update_pulse), 32'h0);
    base_p = pulse_cnt;
    scan(7'h06, 7'h5b, 7'h4f, 7'h66, 8);
    scan(7'h06, 7'h5b, 7'h4f, 7'h66, 8);
    run(4'b0000, 7'h00, 4);
    chk("t6_two_valid", 32'(valid_out), 32'h0);
    scan(7'h06, 7'h5b, 7'h4f, 7'h66, 8);
    run(4'b0000, 7'h00, 4);
    chk("t6_digits", 32'(digits_out), 32'h4321);
    chk("t6_valid", 32'(valid_out), 32'hF);
    chk("t6_pulses", 32'(pulse_cnt - base_p), 32'd4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
